// File: rtl/trace_window_filter.sv
// Sequential PC/privilege trace filter: per-range include/exclude comparators, privilege mask,
// start/stop trigger window with emit budget, registered enable and per-range saturating hit counters.
module trace_window_filter #(
    parameter int unsigned NUM_RANGES = 8,
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned IDX_W      = ($clog2(NUM_RANGES) > 0) ? $clog2(NUM_RANGES) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         trace_valid_i,
    input  logic [ADDR_W-1:0]            pc_i,
    input  logic [1:0]                   priv_lvl_i,
    input  logic [2:0]                   priv_en_i,
    input  logic [NUM_RANGES-1:0]        range_en_i,
    input  logic [NUM_RANGES-1:0]        range_excl_i,
    input  logic [NUM_RANGES*ADDR_W-1:0] range_base_i,
    input  logic [NUM_RANGES*ADDR_W-1:0] range_last_i,
    input  logic                         trig_en_i,
    input  logic [IDX_W-1:0]             start_idx_i,
    input  logic                         stop_en_i,
    input  logic [IDX_W-1:0]             stop_idx_i,
    input  logic [CNT_W-1:0]             budget_i,
    input  logic                         arm_i,
    input  logic                         disarm_i,
    input  logic                         clr_cnt_i,
    output logic                         valid_o,
    output logic                         enable_o,
    output logic [1:0]                   state_o,
    output logic [CNT_W-1:0]             emit_cnt_o,
    output logic [NUM_RANGES*CNT_W-1:0]  hit_cnt_o
);

    localparam int unsigned PAD_N = 1 << IDX_W;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        ACTIVE  = 2'd2,
        STOPPED = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    emit_cnt;
    logic [NUM_RANGES-1:0] raw;
    logic [NUM_RANGES-1:0] hit;
    logic [PAD_N-1:0]    raw_pad;
    logic                priv_ok;
    logic                inc_any;
    logic                exc_any;
    logic                pass;
    logic                start_hit;
    logic                stop_hit;
    logic                eligible;
    logic                budget_ok;
    logic                emit;
    logic                budget_done;
    logic                arm_start;

    always_comb begin
        case (priv_lvl_i)
            2'b11:   priv_ok = priv_en_i[2];
            2'b01:   priv_ok = priv_en_i[1];
            2'b00:   priv_ok = priv_en_i[0];
            default: priv_ok = 1'b0;
        endcase
    end

    assign hit     = raw & range_en_i;
    assign inc_any = |(hit & ~range_excl_i);
    assign exc_any = |(hit & range_excl_i);
    assign pass    = priv_ok & inc_any & ~exc_any;

    // Trigger indices may point past NUM_RANGES; padded entries never match.
    assign raw_pad   = PAD_N'(raw);
    assign start_hit = raw_pad[start_idx_i];
    assign stop_hit  = stop_en_i & raw_pad[stop_idx_i];

    assign eligible    = trace_valid_i & ~disarm_i &
                         ((state == ACTIVE) | ((state == ARMED) & start_hit));
    assign budget_ok   = (budget_i == '0) | (emit_cnt < budget_i);
    assign emit        = eligible & pass & budget_ok;
    assign budget_done = emit & (budget_i != '0) & ((emit_cnt + CNT_W'(1)) == budget_i);
    assign arm_start   = arm_i & ~disarm_i & ((state == IDLE) | (state == STOPPED));

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state    <= IDLE;
            valid_o  <= 1'b0;
            enable_o <= 1'b0;
            emit_cnt <= '0;
        end else begin
            valid_o  <= trace_valid_i;
            enable_o <= emit;
            if (disarm_i) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE, STOPPED: if (arm_i) state <= trig_en_i ? ARMED : ACTIVE;
                    ARMED, ACTIVE: if (eligible) state <= (stop_hit | budget_done) ? STOPPED : ACTIVE;
                    default:       state <= IDLE;
                endcase
            end
            if (clr_cnt_i || arm_start) begin
                emit_cnt <= '0;
            end else if (emit && !(&emit_cnt)) begin
                emit_cnt <= emit_cnt + CNT_W'(1);
            end
        end
    end

    for (genvar k = 0; k < NUM_RANGES; k++) begin : g_range
        logic [CNT_W-1:0] cnt;

        assign raw[k] = (range_base_i[k*ADDR_W +: ADDR_W] <= pc_i) &&
                        (pc_i <= range_last_i[k*ADDR_W +: ADDR_W]);

        always_ff @(posedge clk_i) begin
            if (!rst_ni || clr_cnt_i) begin
                cnt <= '0;
            end else if (eligible && priv_ok && hit[k] && !(&cnt)) begin
                cnt <= cnt + CNT_W'(1);
            end
        end

        assign hit_cnt_o[k*CNT_W +: CNT_W] = cnt;
    end

    assign state_o    = state;
    assign emit_cnt_o = emit_cnt;

endmodule
